pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Generic, parametrised inter-stage pipeline register for the 5-stage CPU (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one packed stage bundle (control bits, data words, destination register, PC+8, hazard-class tags) as a single WIDTH-bit vector.
- Adds what the fixed per-stage registers lack: valid/ready handshake for stall, synchronous flush to bubble, an optional 2-entry skid buffer that breaks the combinational ready path, and guaranteed all-zero bubbles so RegWrite/MemWrite can never leak.

Parameters:
- WIDTH, 32: width of in_data/out_data bundle in bits (1..1024).
- SKID_EN, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- ZERO_BUBBLE, 1: 1 = out_data forced to all-zero whenever out_valid=0; 0 = out_data holds its last value.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous flush; empties the stage (branch/jump/exception squash).
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  stage can accept a bundle this cycle.
- in_data  in  WIDTH  upstream bundle.
- out_valid  out  1  bundle presented to the downstream stage.
- out_ready  in  1  downstream consumes the bundle this cycle.
- out_data  out  WIDTH  bundle to the downstream stage.
- occupancy  out  2  number of held entries (0..2).

Behaviour:
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. All state updates occur on posedge clk.
- Reset (asynchronous): out_valid=0, out_data=0, occupancy=0, skid entry cleared. in_ready=1 when SKID_EN=1. When SKID_EN=0, in_ready=1 because the stage is empty.
- Latency: in_fire in cycle N gives out_valid=1 with that data in cycle N+1. Sustained throughput is 1 bundle/cycle with out_ready held at 1.
- Bundles leave in the order they entered; none are dropped or duplicated except by flush.
- States (SKID_EN=1): EMPTY(occ 0), ONE(occ 1, main valid), TWO(occ 2, main+skid valid).
  - EMPTY: in_fire -> ONE, main<=in_data.
  - ONE: in_fire & out_fire -> ONE, main<=in_data. in_fire & !out_fire -> TWO, skid<=in_data. !in_fire & out_fire -> EMPTY. Otherwise hold.
  - TWO: in_ready=0. out_fire -> ONE, main<=skid. Otherwise hold.
- in_ready (SKID_EN=1) is a flop equal to (next state != TWO); there is no combinational path from out_ready to in_ready.
- SKID_EN=0: states EMPTY/ONE only. in_ready = out_ready | ~out_valid (combinational). TWO is unreachable and occupancy is never 2.
- Flush has priority over everything. Next state is EMPTY; out_valid=0 in the next cycle.
  - in_fire in the flush cycle is discarded.
  - out_fire in the flush cycle still counts as delivered.
  - in_ready is still driven normally in the flush cycle.
- ZERO_BUBBLE=1: data registers are loaded with 0 on drain-to-EMPTY and on flush, so out_data=0 whenever out_valid=0.
- out_data is driven directly from the main register; there is no mux after the flop.
- Stall: out_ready=0 holds out_data and out_valid stable; the bundle is never modified while it is presented.
- Reset asserted mid-transfer discards all held entries immediately, without waiting for a clock edge.
- in_data is ignored whenever in_fire=0; X on in_data while in_valid=0 must not propagate.

Decomposition:
- Shared package cpu_pipe_pkg:
  - bundle-width constants for each stage (MEM_WB_W, EX_MEM_W, ...);
  - field-offset localparams for RegWrite, MemtoReg[1:0], ReadData, ALUOut, WriteReg, PC8, and the cal_r/cal_i/ld/st/jal tags;
  - occupancy encodings OCC_EMPTY/OCC_ONE/OCC_TWO.
- One natural sub-module: pipe_data_reg.
  - WIDTH-bit register with async reset, load enable, and synchronous clear.
  - Instantiated twice, once for main and once for skid; skid is omitted when SKID_EN=0.

Test Plan:
- Streaming: after reset, drive in_valid=1 with data 0x11, 0x22, 0x33 on consecutive cycles and hold out_ready=1 -> out_data shows 0x11, 0x22, 0x33 in cycles 1, 2, 3; in_ready stays 1; occupancy stays 1.
- Backpressure: out_ready=0 while sending 0xAA then 0xBB -> occupancy=2 and in_ready=0 in the next cycle; out_data holds 0xAA. Then raise out_ready -> 0xAA, then 0xBB; occupancy steps 2->1->0.
- Flush: with occupancy=2 (0xAA, 0xBB), assert flush together with in_valid and data 0xCC -> next cycle out_valid=0, out_data=0, occupancy=0; 0xCC never appears.
- Async reset: assert reset mid-cycle while holding 0x5A5A5A5A -> out_valid=0 and out_data=0 immediately. After deassertion, in_ready=1 and occupancy=0.
- SKID_EN=0: pulse out_ready=0 for one cycle with in_valid=1 -> in_ready falls in the same cycle; occupancy never reaches 2; data order is preserved.
- ZERO_BUBBLE=0 with WIDTH=107 (MEM_WB bundle): drain the stage -> out_data retains the last bundle while out_valid=0. Repeat with ZERO_BUBBLE=1 -> out_data=0, including the RegWrite bit.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the 5-stage CPU pipeline registers: bundle widths,
// MEM/WB field offsets, hazard-class tags and stage-occupancy encodings.
package cpu_pipe_pkg;

  localparam int unsigned IF_ID_W  = 64;
  localparam int unsigned ID_EX_W  = 147;
  localparam int unsigned EX_MEM_W = 107;
  localparam int unsigned MEM_WB_W = 107;

  // MEM/WB bundle layout, LSB first
  localparam int unsigned MW_REGWRITE     = 0;
  localparam int unsigned MW_MEMTOREG_LSB = 1;    // [2:1]
  localparam int unsigned MW_WRITEREG_LSB = 3;    // [7:3]
  localparam int unsigned MW_READDATA_LSB = 8;    // [39:8]
  localparam int unsigned MW_ALUOUT_LSB   = 40;   // [71:40]
  localparam int unsigned MW_PC8_LSB      = 72;   // [103:72]
  localparam int unsigned MW_TAG_LSB      = 104;  // [106:104] hazard class
  localparam int unsigned MW_TAG_W        = 3;

  typedef enum logic [2:0] {
    TAG_NONE  = 3'd0,
    TAG_CAL_R = 3'd1,
    TAG_CAL_I = 3'd2,
    TAG_LD    = 3'd3,
    TAG_ST    = 3'd4,
    TAG_JAL   = 3'd5
  } hz_tag_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-bit data register with async reset, load enable and synchronous
// clear (clear wins over load).
module pipe_data_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (clear)     data_d = '0;
    else if (load) data_d = d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, flush-to-bubble
// and an optional 2-entry skid buffer that registers in_ready.
module pipe_stage_skid
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter bit          SKID_EN     = 1'b1,
  parameter bit          ZERO_BUBBLE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  occ_e             state_d, state_q;
  logic             in_fire, out_fire;
  logic             main_load, main_clr, main_from_skid;
  logic             skid_load, skid_clr;
  logic [WIDTH-1:0] main_in, main_q, skid_q;

  assign out_valid = (state_q != OCC_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = main_q;
  assign occupancy = state_q;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_d  = OCC_EMPTY;
      main_clr = ZERO_BUBBLE;
      skid_clr = 1'b1;
    end else begin
      unique case (state_q)
        OCC_EMPTY: if (in_fire) begin
          state_d   = OCC_ONE;
          main_load = 1'b1;
        end
        OCC_ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire && SKID_EN) begin
            state_d   = OCC_TWO;
            skid_load = 1'b1;
          end else if (out_fire) begin
            state_d  = OCC_EMPTY;
            main_clr = ZERO_BUBBLE;
          end
        end
        OCC_TWO: if (out_fire) begin
          state_d        = OCC_ONE;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_clr       = 1'b1;
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= OCC_EMPTY;
    else       state_q <= state_d;
  end

  assign main_in = main_from_skid ? skid_q : in_data;

  pipe_data_reg #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .clear (main_clr),
    .d     (main_in),
    .q     (main_q)
  );

  generate
    if (SKID_EN) begin : g_skid
      logic in_ready_d, in_ready_q;

      pipe_data_reg #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .clear (skid_clr),
        .d     (in_data),
        .q     (skid_q)
      );

      // Ready is a flop looking at the next state, so out_ready never
      // reaches in_ready combinationally.
      assign in_ready_d = (state_d != OCC_TWO);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) in_ready_q <= 1'b1;
        else       in_ready_q <= in_ready_d;
      end

      assign in_ready = in_ready_q;
    end else begin : g_noskid
      logic unused_skid;

      assign skid_q      = '0;
      assign unused_skid = skid_load ^ skid_clr;
      assign in_ready    = out_ready | ~out_valid;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench: four configurations share one stimulus stream and are
// compared every cycle against per-instance FIFO reference models.
module tb_pipe_stage_skid;
  import cpu_pipe_pkg::*;

  localparam int unsigned WW = 107;

  logic clk = 1'b0;
  logic reset, flush, in_valid, out_ready;
  logic [WW-1:0] in_data;

  logic          ir [4];
  logic          ov [4];
  logic [1:0]    occ [4];
  logic [WW-1:0] od [4];
  logic [31:0]   od_a, od_b;
  logic [WW-1:0] od_c, od_d;

  int checks = 0;
  int errors = 0;

  // Per-instance configuration: skid enabled, zero bubble, 32-bit wide
  bit skid_p   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  bit zb_p     [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  bit narrow_p [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  // Reference model: ordered list of held bundles per instance
  logic [WW-1:0] ent  [4][2];
  int            cnt  [4];
  logic [WW-1:0] last [4];
  bit            rdy_reg [4];

  always #5 clk = ~clk;

  pipe_stage_skid #(.WIDTH(32), .SKID_EN(1'b1), .ZERO_BUBBLE(1'b1)) u_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data[31:0]), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od_a), .occupancy(occ[0]));

  pipe_stage_skid #(.WIDTH(32), .SKID_EN(1'b0), .ZERO_BUBBLE(1'b1)) u_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data[31:0]), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od_b), .occupancy(occ[1]));

  pipe_stage_skid #(.WIDTH(MEM_WB_W), .SKID_EN(1'b1), .ZERO_BUBBLE(1'b0)) u_c (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
    .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready),
    .out_data(od_c), .occupancy(occ[2]));

  pipe_stage_skid #(.WIDTH(MEM_WB_W), .SKID_EN(1'b1), .ZERO_BUBBLE(1'b1)) u_d (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[3]),
    .in_data(in_data), .out_valid(ov[3]), .out_ready(out_ready),
    .out_data(od_d), .occupancy(occ[3]));

  assign od[0] = WW'(od_a);
  assign od[1] = WW'(od_b);
  assign od[2] = od_c;
  assign od[3] = od_d;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit model_rdy(input int i);
    if (skid_p[i]) return rdy_reg[i];
    return (cnt[i] == 0) || out_ready;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      cnt[i]     = 0;
      last[i]    = '0;
      rdy_reg[i] = 1'b1;
    end
  endtask

  // Applied at the rising edge with the inputs that were held during the cycle
  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      bit fi, fo;
      logic [WW-1:0] d;
      d  = narrow_p[i] ? (in_data & WW'(32'hFFFF_FFFF)) : in_data;
      fi = in_valid && model_rdy(i);
      fo = (cnt[i] > 0) && out_ready;
      if (flush) begin
        cnt[i] = 0;
      end else begin
        if (fo) begin
          ent[i][0] = ent[i][1];
          cnt[i]--;
        end
        if (fi) begin
          ent[i][cnt[i]] = d;
          cnt[i]++;
        end
      end
      if (cnt[i] > 0) last[i] = ent[i][0];
      rdy_reg[i] = (cnt[i] < 2);
    end
  endtask

  task automatic check_models();
    for (int i = 0; i < 4; i++) begin
      logic [WW-1:0] exp_d;
      exp_d = (cnt[i] > 0) ? ent[i][0] : (zb_p[i] ? '0 : last[i]);
      chk($sformatf("dut%0d out_valid", i), WW'(ov[i]), WW'(cnt[i] > 0));
      chk($sformatf("dut%0d out_data", i), od[i], exp_d);
      chk($sformatf("dut%0d in_ready", i), WW'(ir[i]), WW'(model_rdy(i)));
      chk($sformatf("dut%0d occupancy", i), WW'(occ[i]), WW'(cnt[i]));
    end
  endtask

  task automatic apply(input bit v, input bit r, input bit f, input logic [WW-1:0] d);
    @(negedge clk);
    in_valid  = v;
    out_ready = r;
    flush     = f;
    in_data   = d;
    #1;
    check_models();
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
  endtask

  typedef struct {
    bit          v, r, f;
    logic [31:0] d;
    bit          eov;
    logic [31:0] eod;
    bit          eir;
    logic [1:0]  eocc;
  } vec_t;

  vec_t tbl [14];
  logic [WW-1:0] big;

  initial begin
    // Streaming, backpressure and flush on the 32-bit skid instance
    tbl[0]  = '{1, 1, 0, 32'h11, 0, 32'h00, 1, 2'd0};
    tbl[1]  = '{1, 1, 0, 32'h22, 1, 32'h11, 1, 2'd1};
    tbl[2]  = '{1, 1, 0, 32'h33, 1, 32'h22, 1, 2'd1};
    tbl[3]  = '{0, 1, 0, 32'h00, 1, 32'h33, 1, 2'd1};
    tbl[4]  = '{1, 0, 0, 32'hAA, 0, 32'h00, 1, 2'd0};
    tbl[5]  = '{1, 0, 0, 32'hBB, 1, 32'hAA, 1, 2'd1};
    tbl[6]  = '{0, 0, 0, 32'h00, 1, 32'hAA, 0, 2'd2};
    tbl[7]  = '{0, 1, 0, 32'h00, 1, 32'hAA, 0, 2'd2};
    tbl[8]  = '{0, 1, 0, 32'h00, 1, 32'hBB, 1, 2'd1};
    tbl[9]  = '{1, 0, 0, 32'hAA, 0, 32'h00, 1, 2'd0};
    tbl[10] = '{1, 0, 0, 32'hBB, 1, 32'hAA, 1, 2'd1};
    tbl[11] = '{1, 0, 1, 32'hCC, 1, 32'hAA, 0, 2'd2};
    tbl[12] = '{0, 1, 0, 32'h00, 0, 32'h00, 1, 2'd0};
    tbl[13] = '{0, 1, 0, 32'h00, 0, 32'h00, 1, 2'd0};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset out_valid", WW'(ov[0]), '0);
    chk("reset in_ready", WW'(ir[0]), WW'(1));
    reset = 1'b0;

    for (int k = 0; k < 14; k++) begin
      apply(tbl[k].v, tbl[k].r, tbl[k].f, WW'(tbl[k].d));
      chk($sformatf("tbl%0d out_valid", k), WW'(ov[0]), WW'(tbl[k].eov));
      chk($sformatf("tbl%0d out_data", k), od[0], WW'(tbl[k].eod));
      chk($sformatf("tbl%0d in_ready", k), WW'(ir[0]), WW'(tbl[k].eir));
      chk($sformatf("tbl%0d occupancy", k), WW'(occ[0]), WW'(tbl[k].eocc));
      advance();
    end

    // Asynchronous reset in the middle of a cycle while holding a bundle
    apply(1, 0, 0, WW'(32'h5A5A_5A5A));
    advance();
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre-reset hold", od[0], WW'(32'h5A5A_5A5A));
    #1 reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("async reset dut%0d out_valid", i), WW'(ov[i]), '0);
      chk($sformatf("async reset dut%0d out_data", i), od[i], '0);
    end
    reset = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("post reset dut%0d in_ready", i), WW'(ir[i]), WW'(1));
      chk($sformatf("post reset dut%0d occupancy", i), WW'(occ[i]), '0);
    end

    // Single-entry stage: ready follows out_ready in the same cycle
    apply(1, 1, 0, WW'(32'h01));
    chk("noskid ready idle", WW'(ir[1]), WW'(1));
    advance();
    apply(1, 0, 0, WW'(32'h02));
    chk("noskid ready drop", WW'(ir[1]), '0);
    chk("noskid hold data", od[1], WW'(32'h01));
    advance();
    apply(1, 1, 0, WW'(32'h02));
    chk("noskid ready back", WW'(ir[1]), WW'(1));
    chk("noskid data kept", od[1], WW'(32'h01));
    advance();
    apply(0, 1, 0, 'x);
    chk("noskid next data", od[1], WW'(32'h02));
    advance();
    apply(0, 1, 0, 'x);
    advance();

    // Drain of a MEM/WB-wide bundle with and without zero bubbles
    big = WW'({$urandom, $urandom, $urandom, $urandom});
    big[MW_REGWRITE] = 1'b1;
    apply(1, 1, 0, big);
    advance();
    apply(0, 1, 0, 'x);
    chk("wide presented", od[2], big);
    advance();
    apply(0, 0, 0, 'x);
    chk("zb0 drained valid", WW'(ov[2]), '0);
    chk("zb0 retains bundle", od[2], big);
    chk("zb1 drained data", od[3], '0);
    chk("zb1 regwrite", WW'(od[3][MW_REGWRITE]), '0);
    advance();

    // Randomized traffic, X on in_data while invalid
    for (int n = 0; n < 600; n++) begin
      bit v, r, f;
      v = ($urandom_range(0, 3) != 0);
      r = (n < 300) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 15) == 0);
      apply(v, r, f, v ? WW'({$urandom, $urandom, $urandom, $urandom}) : 'x);
      advance();
    end
    apply(0, 1, 0, 'x);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
